// File: rtl/target_pkg.sv
// rtl/target_pkg.sv - shared defaults, derived widths and types for the target frame controller
//
// Purpose: default screen / slot geometry, the derived field widths, the
// controller state encoding and the per-slot target record.
// Ports: none (package).

package target_pkg;

  localparam int NUM_TARGETS   = 4;
  localparam int SCREEN_WIDTH  = 1280;
  localparam int SCREEN_HEIGHT = 720;

  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT) + 1;
  localparam int IW = $clog2(NUM_TARGETS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [YW-1:0] diam;
    logic          valid;
  } target_t;

endpackage

// File: rtl/target_pick.sv
// rtl/target_pick.sv - lowest-pending-slot selector
//
// Purpose: from a mask of slots still waiting to be sent, return the lowest
// pending index, whether anything is pending, and whether that slot is the
// final one (no other pending slot above it).
// Ports:
//   pending  in   NUM_TARGETS  slots still to be sent
//   idx      out  IW           lowest pending slot (0 when none)
//   any      out  1            at least one slot pending
//   last     out  1            the selected slot is the only one pending

module target_pick #(
  parameter int NUM_TARGETS = target_pkg::NUM_TARGETS,
  parameter int IW          = $clog2(NUM_TARGETS)
) (
  input  logic [NUM_TARGETS-1:0] pending,
  output logic [IW-1:0]          idx,
  output logic                   any,
  output logic                   last
);

  localparam logic [NUM_TARGETS-1:0] ONE = {{(NUM_TARGETS-1){1'b0}}, 1'b1};

  always_comb begin
    idx = '0;
    // Scan downward so the lowest set bit is the one left in idx.
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        idx = IW'(i);
      end
    end
  end

  assign any = |pending;

  // Since idx is the lowest pending bit, it is last exactly when it is the
  // only pending bit: clearing the lowest set bit leaves nothing.
  assign last = any && ((pending & (pending - ONE)) == '0);

endmodule

// File: rtl/target_frame_ctrl.sv
// rtl/target_frame_ctrl.sv - per-frame detector snapshot and target beat streamer
//
// Purpose: at each frame end, snapshot the detector slots, pulse a detector
// clear, then stream every valid slot in index order over a valid/ready
// channel, finishing with a frame-done pulse and a frame counter increment.
// Ports:
//   clk_in, rst_in                      clock, async active-high reset
//   hcount_in, vcount_in                raster position
//   det_x_in/det_y_in/det_diam_in       packed detector slot fields
//   det_valid_in                        detector slot valid bits
//   det_clear_out                       one-cycle detector reset request
//   tgt_valid_out, tgt_ready_in         target beat handshake
//   tgt_x_out/tgt_y_out/tgt_diam_out    target beat payload
//   tgt_idx_out, tgt_last_out           source slot, final beat of frame
//   frame_done_out, frame_count_out     end-of-stream pulse, completed frames
//   overrun_out                         sticky: frame end seen while busy

module target_frame_ctrl
  import target_pkg::*;
#(
  parameter int NUM_TARGETS   = target_pkg::NUM_TARGETS,
  parameter int SCREEN_WIDTH  = target_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = target_pkg::SCREEN_HEIGHT,
  localparam int XW = $clog2(SCREEN_WIDTH),
  localparam int YW = $clog2(SCREEN_HEIGHT) + 1,
  localparam int IW = $clog2(NUM_TARGETS)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [XW:0]               hcount_in,
  input  logic [YW-1:0]             vcount_in,
  input  logic [NUM_TARGETS*XW-1:0] det_x_in,
  input  logic [NUM_TARGETS*YW-1:0] det_y_in,
  input  logic [NUM_TARGETS*YW-1:0] det_diam_in,
  input  logic [NUM_TARGETS-1:0]    det_valid_in,
  output logic                      det_clear_out,
  output logic                      tgt_valid_out,
  input  logic                      tgt_ready_in,
  output logic [XW-1:0]             tgt_x_out,
  output logic [YW-1:0]             tgt_y_out,
  output logic [YW-1:0]             tgt_diam_out,
  output logic [IW-1:0]             tgt_idx_out,
  output logic                      tgt_last_out,
  output logic                      frame_done_out,
  output logic [15:0]               frame_count_out,
  output logic                      overrun_out
);

  localparam logic [NUM_TARGETS-1:0] ONE = {{(NUM_TARGETS-1){1'b0}}, 1'b1};

  state_t state;

  logic fe_now;
  logic fe_prev;
  logic fe;

  logic [XW-1:0] snap_x    [NUM_TARGETS];
  logic [YW-1:0] snap_y    [NUM_TARGETS];
  logic [YW-1:0] snap_diam [NUM_TARGETS];
  logic [NUM_TARGETS-1:0] snap_valid;
  logic [NUM_TARGETS-1:0] sent;
  logic [NUM_TARGETS-1:0] pending;
  logic [NUM_TARGETS-1:0] pick_mask;

  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          pick_last;
  logic          handshake;

  // Frame end is the first cycle of the (0, SCREEN_HEIGHT) raster position;
  // holding that position for several cycles still yields a single event.
  assign fe_now    = (hcount_in == '0) && (vcount_in == YW'(SCREEN_HEIGHT));
  assign fe        = fe_now && !fe_prev;
  assign handshake = tgt_valid_out && tgt_ready_in;
  assign pending   = snap_valid & ~sent;

  // Pick the next beat from the mask as it will be after this cycle's
  // handshake, so the following slot is loaded without a bubble. The ready
  // input only reaches registers, never the valid output directly.
  always_comb begin
    pick_mask = pending;
    if (handshake) begin
      pick_mask = pending & ~(ONE << tgt_idx_out);
    end
  end

  target_pick #(
    .NUM_TARGETS (NUM_TARGETS),
    .IW          (IW)
  ) u_pick (
    .pending (pick_mask),
    .idx     (pick_idx),
    .any     (pick_any),
    .last    (pick_last)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= ST_IDLE;
      fe_prev         <= 1'b0;
      snap_valid      <= '0;
      sent            <= '0;
      for (int i = 0; i < NUM_TARGETS; i++) begin
        snap_x[i]    <= '0;
        snap_y[i]    <= '0;
        snap_diam[i] <= '0;
      end
      det_clear_out   <= 1'b0;
      tgt_valid_out   <= 1'b0;
      tgt_x_out       <= '0;
      tgt_y_out       <= '0;
      tgt_diam_out    <= '0;
      tgt_idx_out     <= '0;
      tgt_last_out    <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_count_out <= '0;
      overrun_out     <= 1'b0;
    end else begin
      fe_prev        <= fe_now;
      det_clear_out  <= 1'b0;
      frame_done_out <= 1'b0;

      // A frame end while the previous frame is still in flight is dropped.
      if (fe && state != ST_IDLE) begin
        overrun_out <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (fe) begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
              snap_x[i]    <= det_x_in[i*XW +: XW];
              snap_y[i]    <= det_y_in[i*YW +: YW];
              snap_diam[i] <= det_diam_in[i*YW +: YW];
            end
            snap_valid    <= det_valid_in;
            sent          <= '0;
            det_clear_out <= 1'b1;
            state         <= ST_CLEAR;
          end
        end

        ST_CLEAR: begin
          if (pick_any) begin
            tgt_valid_out <= 1'b1;
            tgt_x_out     <= snap_x[pick_idx];
            tgt_y_out     <= snap_y[pick_idx];
            tgt_diam_out  <= snap_diam[pick_idx];
            tgt_idx_out   <= pick_idx;
            tgt_last_out  <= pick_last;
            state         <= ST_STREAM;
          end else begin
            frame_done_out  <= 1'b1;
            frame_count_out <= frame_count_out + 16'd1;
            state           <= ST_DONE;
          end
        end

        ST_STREAM: begin
          if (handshake) begin
            sent[tgt_idx_out] <= 1'b1;
            if (tgt_last_out) begin
              tgt_valid_out   <= 1'b0;
              tgt_x_out       <= '0;
              tgt_y_out       <= '0;
              tgt_diam_out    <= '0;
              tgt_idx_out     <= '0;
              tgt_last_out    <= 1'b0;
              frame_done_out  <= 1'b1;
              frame_count_out <= frame_count_out + 16'd1;
              state           <= ST_DONE;
            end else begin
              tgt_x_out    <= snap_x[pick_idx];
              tgt_y_out    <= snap_y[pick_idx];
              tgt_diam_out <= snap_diam[pick_idx];
              tgt_idx_out  <= pick_idx;
              tgt_last_out <= pick_last;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_target_frame_ctrl.sv
// tb/tb_target_frame_ctrl.sv - self-checking bench for target_frame_ctrl

module tb_target_frame_ctrl;
  import target_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [XW:0]               hcount;
  logic [YW-1:0]             vcount;
  logic [NUM_TARGETS*XW-1:0] det_x;
  logic [NUM_TARGETS*YW-1:0] det_y;
  logic [NUM_TARGETS*YW-1:0] det_diam;
  logic [NUM_TARGETS-1:0]    det_valid;
  logic                      det_clear;
  logic                      tgt_valid;
  logic                      tgt_ready;
  logic [XW-1:0]             tgt_x;
  logic [YW-1:0]             tgt_y;
  logic [YW-1:0]             tgt_diam;
  logic [IW-1:0]             tgt_idx;
  logic                      tgt_last;
  logic                      frame_done;
  logic [15:0]               frame_count;
  logic                      overrun;

  int   checks = 0;
  int   errors = 0;
  int   fc_exp = 0;
  logic ovr_exp = 1'b0;

  target_frame_ctrl dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .hcount_in       (hcount),
    .vcount_in       (vcount),
    .det_x_in        (det_x),
    .det_y_in        (det_y),
    .det_diam_in     (det_diam),
    .det_valid_in    (det_valid),
    .det_clear_out   (det_clear),
    .tgt_valid_out   (tgt_valid),
    .tgt_ready_in    (tgt_ready),
    .tgt_x_out       (tgt_x),
    .tgt_y_out       (tgt_y),
    .tgt_diam_out    (tgt_diam),
    .tgt_idx_out     (tgt_idx),
    .tgt_last_out    (tgt_last),
    .frame_done_out  (frame_done),
    .frame_count_out (frame_count),
    .overrun_out     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fe(input logic on);
    if (on) begin
      hcount = '0;
      vcount = YW'(SCREEN_HEIGHT);
    end else begin
      hcount = (XW+1)'($urandom_range(1, SCREEN_WIDTH - 1));
      vcount = YW'($urandom_range(0, SCREEN_HEIGHT - 1));
    end
  endtask

  task automatic scramble_det();
    for (int i = 0; i < NUM_TARGETS; i++) begin
      det_x[i*XW +: XW]    = XW'($urandom_range(0, SCREEN_WIDTH - 1));
      det_y[i*YW +: YW]    = YW'($urandom_range(0, SCREEN_HEIGHT - 1));
      det_diam[i*YW +: YW] = YW'($urandom_range(1, 64));
    end
    det_valid = NUM_TARGETS'($urandom);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_det_clear"},   32'(det_clear),   32'd0);
    check({pfx, "_tgt_valid"},   32'(tgt_valid),   32'd0);
    check({pfx, "_tgt_x"},       32'(tgt_x),       32'd0);
    check({pfx, "_tgt_y"},       32'(tgt_y),       32'd0);
    check({pfx, "_tgt_diam"},    32'(tgt_diam),    32'd0);
    check({pfx, "_tgt_idx"},     32'(tgt_idx),     32'd0);
    check({pfx, "_tgt_last"},    32'(tgt_last),    32'd0);
    check({pfx, "_frame_done"},  32'(frame_done),  32'd0);
    check({pfx, "_frame_count"}, 32'(frame_count), 32'd0);
    check({pfx, "_overrun"},     32'(overrun),     32'd0);
  endtask

  // One frame: snapshot model built from the applied detector values, the
  // expected beat order is simply the valid slot indices in ascending order.
  // rmode: 0 ready=1, 1 random, 2 low for first 5 cycles, 3 low for first 8.
  task automatic run_frame(input logic [NUM_TARGETS-1:0] vmask, input int rmode,
                           input int fe_hold, input int inj, input bit fixed);
    target_t snap [NUM_TARGETS];
    int      idxq [$];
    int      it;
    int      fe_left;
    int      k;
    logic    r;
    logic    inj_now;

    scramble_det();
    det_valid = vmask;
    if (fixed) begin
      det_x[0*XW +: XW] = XW'(100); det_y[0*YW +: YW] = YW'(50);  det_diam[0*YW +: YW] = YW'(8);
      det_x[2*XW +: XW] = XW'(640); det_y[2*YW +: YW] = YW'(360); det_diam[2*YW +: YW] = YW'(20);
    end
    for (int i = 0; i < NUM_TARGETS; i++) begin
      snap[i].x     = det_x[i*XW +: XW];
      snap[i].y     = det_y[i*YW +: YW];
      snap[i].diam  = det_diam[i*YW +: YW];
      snap[i].valid = vmask[i];
      if (snap[i].valid) idxq.push_back(i);
    end

    set_fe(1'b1);
    step();
    check("clear_pulse", 32'(det_clear), 32'd1);
    check("valid_in_clear", 32'(tgt_valid), 32'd0);

    fe_left = fe_hold - 1;
    scramble_det();
    if (fe_left > 0) begin set_fe(1'b1); fe_left--; end else set_fe(1'b0);
    step();

    it = 0;
    while (1) begin
      check("clear_once", 32'(det_clear), 32'd0);
      check("overrun", 32'(overrun), 32'(ovr_exp));
      if (idxq.size() == 0) begin
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("valid_after_last", 32'(tgt_valid), 32'd0);
        break;
      end
      k = idxq[0];
      check("frame_done_early", 32'(frame_done), 32'd0);
      check("beat_valid", 32'(tgt_valid), 32'd1);
      check("beat_x",    32'(tgt_x),    32'(snap[k].x));
      check("beat_y",    32'(tgt_y),    32'(snap[k].y));
      check("beat_diam", 32'(tgt_diam), 32'(snap[k].diam));
      check("beat_idx",  32'(tgt_idx),  32'(k));
      check("beat_last", 32'(tgt_last), 32'(idxq.size() == 1));

      case (rmode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        2:       r = (it >= 5);
        default: r = (it >= 8);
      endcase
      tgt_ready = r;
      if (r) void'(idxq.pop_front());

      scramble_det();
      inj_now = 1'b0;
      if (it == inj) begin
        set_fe(1'b1);
        inj_now = 1'b1;
      end else if (fe_left > 0) begin
        set_fe(1'b1);
        fe_left--;
      end else begin
        set_fe(1'b0);
      end
      step();
      if (inj_now) ovr_exp = 1'b1;
      it++;
      if (it > 200) begin
        checks++;
        errors++;
        $error("FAIL frame_timeout observed=no_frame_done expected=frame_done");
        break;
      end
    end

    fc_exp = (fc_exp + 1) & 16'hFFFF;
    set_fe(1'b0);
    step();
    check("frame_done_one_cycle", 32'(frame_done), 32'd0);
    check("idle_valid", 32'(tgt_valid), 32'd0);
    check("frame_count", 32'(frame_count), 32'(fc_exp));
  endtask

  initial begin
    rst       = 1'b1;
    hcount    = '0;
    vcount    = '0;
    det_x     = '0;
    det_y     = '0;
    det_diam  = '0;
    det_valid = '0;
    tgt_ready = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    set_fe(1'b0);
    step();
    step();

    // Two valid slots, ready tied high: back-to-back beats, last on idx2.
    run_frame(4'b0101, 0, 1, -1, 1'b1);
    // Same frame with the first beat stalled for five cycles.
    run_frame(4'b0101, 2, 1, -1, 1'b1);
    // No valid slots: done pulse straight after the clear cycle.
    run_frame(4'b0000, 0, 1, -1, 1'b0);
    // All slots valid, stalled, second frame end while streaming.
    run_frame(4'b1111, 3, 1, 3, 1'b0);
    check("overrun_sticky", 32'(overrun), 32'd1);
    // Random masks and random back-pressure.
    for (int n = 0; n < 6; n++) begin
      run_frame(NUM_TARGETS'($urandom), 1, 1, -1, 1'b0);
    end
    // Frame-end position held for three cycles: one capture, one clear.
    run_frame(4'b0110, 1, 3, -1, 1'b0);
    check("overrun_still_set", 32'(overrun), 32'd1);

    // Reset in the middle of a stream, after one beat has been accepted.
    scramble_det();
    det_valid = 4'b0111;
    set_fe(1'b1);
    step();
    set_fe(1'b0);
    tgt_ready = 1'b1;
    step();
    check("pre_reset_idx0", 32'(tgt_idx), 32'd0);
    step();
    check("pre_reset_idx1", 32'(tgt_idx), 32'd1);
    check("pre_reset_valid", 32'(tgt_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    step();
    check_all_zero("midreset_held");
    rst = 1'b0;
    fc_exp  = 0;
    ovr_exp = 1'b0;
    step();
    run_frame(4'b1011, 0, 1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
